decode_ctrl: RTL

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/risc_pkg.sv | 50 +++++
 rtl/instr_fields.sv | 50 +++++
 rtl/decode_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, FSM state
// encodings and instruction field positions used by decode and the ALU.
package risc_pkg;

   // Opcodes (instruction bits [15:12])
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_RDMEM = 4'd6;
   localparam logic [3:0] OP_WRMEM = 4'd7;
   localparam logic [3:0] OP_LOAD  = 4'd8;
   localparam logic [3:0] OP_CMP   = 4'd9;
   localparam logic [3:0] OP_SHL   = 4'd10;
   localparam logic [3:0] OP_SHR   = 4'd11;
   localparam logic [3:0] OP_JMPA  = 4'd12;
   localparam logic [3:0] OP_JMPR  = 4'd13;

   // Instruction field bit positions
   localparam int unsigned F_OP_HI  = 15;
   localparam int unsigned F_OP_LO  = 12;
   localparam int unsigned F_RD_HI  = 11;
   localparam int unsigned F_RD_LO  = 9;
   localparam int unsigned F_FLAG   = 8;
   localparam int unsigned F_RA_HI  = 7;
   localparam int unsigned F_RA_LO  = 5;
   localparam int unsigned F_RB_HI  = 4;
   localparam int unsigned F_RB_LO  = 2;
   localparam int unsigned F_IMM_HI = 7;
   localparam int unsigned F_IMM_LO = 0;

   // Control FSM state encodings (visible on o_state)
   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_REGREAD = 3'd2,
      ST_EXEC    = 3'd3,
      ST_MEM     = 3'd4,
      ST_WB      = 3'd5,
      ST_HALT    = 3'd6
   } state_e;

   // Opcodes 14 and 15 are not assigned to any operation
   function automatic logic is_unassigned(input logic [3:0] op);
      return (op >= 4'd14);
   endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational instruction field extraction and per-opcode class
// lookup (register write-back, memory access, store, unassigned).
module instr_fields
   import risc_pkg::*;
(
   input  logic [15:0] instr_i,
   output logic [3:0]  opcode_o,
   output logic [2:0]  rd_o,
   output logic        flag_o,
   output logic [2:0]  ra_o,
   output logic [2:0]  rb_o,
   output logic [7:0]  imm_o,
   output logic        wr_en_o,
   output logic        mem_o,
   output logic        store_o,
   output logic        illegal_o
);

   assign opcode_o  = instr_i[F_OP_HI:F_OP_LO];
   assign rd_o      = instr_i[F_RD_HI:F_RD_LO];
   assign flag_o    = instr_i[F_FLAG];
   assign ra_o      = instr_i[F_RA_HI:F_RA_LO];
   assign rb_o      = instr_i[F_RB_HI:F_RB_LO];
   assign imm_o     = instr_i[F_IMM_HI:F_IMM_LO];
   assign illegal_o = is_unassigned(opcode_o);

   // Opcode class: which instructions write back and touch data memory
   always_comb begin
      wr_en_o = 1'b0;
      mem_o   = 1'b0;
      store_o = 1'b0;
      unique case (opcode_o)
         OP_RDMEM: begin
            wr_en_o = 1'b1;
            mem_o   = 1'b1;
         end
         OP_WRMEM: begin
            mem_o   = 1'b1;
            store_o = 1'b1;
         end
         OP_JMPA, OP_JMPR, 4'd14, 4'd15: begin
            wr_en_o = 1'b0;
         end
         default: begin
            wr_en_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// Decode/control FSM and program counter for the 16-bit RISC core.
// Define DECODE_TRAP_EN to halt with o_trap on opcodes 14-15 (else NOP).
module decode_ctrl
   import risc_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_imem_data,
   input  logic        i_imem_ack,
   output logic        o_imem_req,
   output logic [15:0] o_pc,
   output logic        o_rf_en,
   output logic        o_rf_we,
   output logic [2:0]  o_sel_a,
   output logic [2:0]  o_sel_b,
   output logic [2:0]  o_sel_d,
   output logic        o_alu_en,
   output logic [4:0]  o_aluop,
   output logic [7:0]  o_imm,
   input  logic [15:0] i_alu_result,
   input  logic        i_shld_branch,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   input  logic        i_dmem_ack,
   output logic [2:0]  o_state,
   output logic        o_trap
);

   state_e      state_q;
   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic        exec2_q;
   logic        br_q;
   logic [15:0] res_q;
   logic        imem_req_q;
   logic        rf_en_q;
   logic        rf_we_q;
   logic        alu_en_q;
   logic        dmem_req_q;
   logic        dmem_we_q;

   logic [3:0]  f_op;
   logic        f_flag;
   logic        f_wr;
   logic        f_mem;
   logic        f_store;
   logic        f_illegal;

   instr_fields u_fields (
      .instr_i   (ir_q),
      .opcode_o  (f_op),
      .rd_o      (o_sel_d),
      .flag_o    (f_flag),
      .ra_o      (o_sel_a),
      .rb_o      (o_sel_b),
      .imm_o     (o_imm),
      .wr_en_o   (f_wr),
      .mem_o     (f_mem),
      .store_o   (f_store),
      .illegal_o (f_illegal)
   );

   assign o_aluop    = {f_op, f_flag};
   assign o_pc       = pc_q;
   assign o_state    = state_q;
   assign o_imem_req = imem_req_q;
   assign o_rf_en    = rf_en_q;
   assign o_rf_we    = rf_we_q;
   assign o_alu_en   = alu_en_q;
   assign o_dmem_req = dmem_req_q;
   assign o_dmem_we  = dmem_we_q;

`ifdef DECODE_TRAP_EN
   logic trap_q;
   assign o_trap = trap_q;
`else
   assign o_trap = 1'b0;
`endif

   // Control FSM: outputs are set on entry to the state that owns them
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         exec2_q    <= 1'b0;
         br_q       <= 1'b0;
         res_q      <= '0;
         imem_req_q <= 1'b0;
         rf_en_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         alu_en_q   <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
`ifdef DECODE_TRAP_EN
         trap_q     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (!imem_req_q) begin
                  imem_req_q <= 1'b1;
               end else if (i_imem_ack) begin
                  imem_req_q <= 1'b0;
                  ir_q       <= i_imem_data;
                  br_q       <= 1'b0;
                  state_q    <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (f_illegal) begin
`ifdef DECODE_TRAP_EN
                  trap_q  <= 1'b1;
                  state_q <= ST_HALT;
`else
                  state_q <= ST_WB;
`endif
               end else begin
                  rf_en_q <= 1'b1;
                  state_q <= ST_REGREAD;
               end
            end
            ST_REGREAD: begin
               rf_en_q  <= 1'b0;
               alu_en_q <= 1'b1;
               exec2_q  <= 1'b0;
               state_q  <= ST_EXEC;
            end
            ST_EXEC: begin
               if (!exec2_q) begin
                  exec2_q <= 1'b1;
               end else begin
                  alu_en_q <= 1'b0;
                  br_q     <= i_shld_branch;
                  res_q    <= i_alu_result;
                  if (f_mem) begin
                     dmem_req_q <= 1'b1;
                     dmem_we_q  <= f_store;
                     state_q    <= ST_MEM;
                  end else begin
                     rf_we_q <= f_wr;
                     state_q <= ST_WB;
                  end
               end
            end
            ST_MEM: begin
               if (i_dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  rf_we_q    <= f_wr;
                  state_q    <= ST_WB;
               end
            end
            ST_WB: begin
               rf_we_q    <= 1'b0;
               pc_q       <= br_q ? res_q : pc_q + 16'd1;
               imem_req_q <= 1'b1;
               state_q    <= ST_FETCH;
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

endmodule
